multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore control FSM for the multicycle RV32I core.
- Sequences the shared ALU, memory port, register file and imm_gen across FETCH, DECODE, EXECUTE, MEM and WB states.
- Drives imm_gen's imm_sel from the latched instruction.
- Includes a memory-wait watchdog and a sticky trap on illegal opcodes.

Parameters:
MAX_WAIT, 255, max cycles spent waiting on mem_ready in any memory state before bus-error trap; 0 disables the watchdog.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- inst  in  32  instruction register contents. Fields used: opcode [6:0], funct3 [14:12], funct7b5 [30].
- zero  in  1  ALU result == 0.
- lt  in  1  signed rs1 < rs2.
- ltu  in  1  unsigned rs1 < rs2.
- mem_ready  in  1  memory accepted/completed the current request this cycle.
- imm_sel  out  3  imm_gen format: I_TYPE, S_TYPE, B_TYPE, U_TYPE or J_TYPE, with encodings from imm_sel.vh.
- alu_src_a  out  2  0=PC, 1=OLDPC, 2=RS1, 3=ZERO.
- alu_src_b  out  2  0=RS2, 1=IMM, 2=FOUR.
- alu_op  out  2  0=ADD, 1=SUB, 2=FUNCT (ALU decoder uses funct3/funct7b5).
- result_sel  out  2  0=ALUOUT register, 1=DATA register, 2=ALU result (combinational).
- adr_sel  out  1  memory address source: 0=PC, 1=ALUOUT.
- mem_req  out  1  memory request valid.
- mem_we  out  1  store request; only ever high together with mem_req.
- ir_we  out  1  latch IR and OLDPC.
- pc_we  out  1  PC <= result.
- reg_we  out  1  rd <= result.
- illegal  out  1  sticky: unknown opcode trapped.
- bus_err  out  1  sticky: watchdog expired.

Behaviour:
- Reset:
  - While rst_n=0 at a clock edge: state <= FETCH, wait counter <= 0, illegal=bus_err=0.
  - During that cycle all enables (mem_req, mem_we, ir_we, pc_we, reg_we) are forced 0.
  - Mux selects go to 0. imm_sel=I_TYPE.
  - Reset overrides every state, including mid-memory wait. No request is held across reset.
- Outputs are combinational decodes of the state register. Exceptions: pc_we in BRANCH, and imm_sel, which is decoded from inst[6:0] in every state.
- imm_sel mapping:
  - I_TYPE: load 0000011, op-imm 0010011, jalr 1100111.
  - S_TYPE: 0100011.
  - B_TYPE: 1100011.
  - U_TYPE: lui 0110111, auipc 0010111.
  - J_TYPE: 1101111.
  - Any other opcode: I_TYPE.
- States, outputs and transitions (unlisted enables = 0):
  - FETCH: mem_req, adr_sel=0, a=PC, b=FOUR, ADD, result_sel=2. Stay until mem_ready. In the mem_ready cycle also assert ir_we and pc_we, then go to DECODE.
  - DECODE: a=OLDPC, b=IMM, ADD (branch/jal target into ALUOUT). Next state by opcode:
    - load/store -> MEMADR
    - R-type 0110011 -> EXECR
    - op-imm -> EXECI
    - branch -> BRANCH
    - jal -> JAL
    - jalr -> JALRADR
    - lui -> LUI
    - auipc -> AUIPC
    - other -> TRAP with illegal<=1
  - MEMADR: a=RS1, b=IMM, ADD. Go to MEMRD if load, MEMWR if store.
  - MEMRD: mem_req, adr_sel=1. On mem_ready go to MEMWB.
  - MEMWB: reg_we, result_sel=1. Go to FETCH.
  - MEMWR: mem_req, mem_we, adr_sel=1. On mem_ready go to FETCH.
  - EXECR: a=RS1, b=RS2, FUNCT. Go to ALUWB.
  - EXECI: a=RS1, b=IMM, FUNCT. Go to ALUWB.
  - ALUWB: reg_we, result_sel=0. Go to FETCH.
  - BRANCH: a=RS1, b=RS2, SUB, result_sel=0. Go to FETCH.
    - pc_we = taken, where taken by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
    - funct3 010/011 -> TRAP with illegal.
  - JALRADR: a=RS1, b=IMM, ADD. Go to JAL.
  - JAL: pc_we, result_sel=0 (target), a=OLDPC, b=FOUR, ADD. Go to ALUWB (rd <= OLDPC+4).
  - LUI: a=ZERO, b=IMM, ADD. Go to ALUWB.
  - AUIPC: a=OLDPC, b=IMM, ADD. Go to ALUWB.
  - TRAP: all enables 0. Stays until reset. illegal/bus_err hold.
- Watchdog:
  - 8-bit counter, cleared on every state change.
  - Increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0.
  - When it reaches MAX_WAIT (MAX_WAIT != 0) with mem_ready still 0: next state TRAP, bus_err<=1.
  - mem_ready in the same cycle as expiry wins: normal transition, no trap.
- CPI: ALU=4, load=5, store=4, branch=3, jal=4, jalr=5, lui/auipc=4. All counts assume mem_ready in the first cycle of each memory state.

Test Plan:
- Reset release, mem_ready=1, inst=0x00C48413 (addi):
  - States FETCH, DECODE, EXECI, ALUWB, FETCH.
  - imm_sel=I_TYPE throughout.
  - reg_we only in cycle 4; ir_we and pc_we only in cycle 1.
- inst=0x0004A403 (lw), mem_ready low for 3 cycles in MEMRD:
  - mem_req/adr_sel=1 held 4 cycles.
  - MEMWB asserts reg_we with result_sel=1.
  - Total 8 cycles.
- inst=0x00A48E63 (beq), imm_sel=B_TYPE:
  - zero=1: pc_we=1 in BRANCH.
  - zero=0: pc_we=0.
  - Both cases return to FETCH after 3 cycles.
- inst=0x7FFFF0EF (jal), imm_sel=J_TYPE:
  - JAL cycle: pc_we=1, result_sel=0.
  - Next cycle ALUWB: reg_we=1.
- inst=0xFFFFFFFF -> DECODE then TRAP:
  - illegal=1 held 20 cycles, no enables.
  - rst_n=0 for 1 edge -> FETCH, illegal=0.
- MAX_WAIT=4, mem_ready=0 in FETCH:
  - TRAP after 4 wait cycles, bus_err=1.
  - Separate run: rst_n=0 asserted during MEMWR wait -> mem_req=0 in the reset cycle, restart in FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// ============================================================================
//  Module   : multicycle_ctrl
//  Purpose  : Control FSM for a multicycle RV32I core. Sequences the shared
//             ALU, memory port, register file and immediate generator through
//             FETCH / DECODE / EXECUTE / MEM / WB states, with a memory-wait
//             watchdog and sticky traps for illegal opcodes and bus timeouts.
//  Ports    : clk, rst_n          - clock, synchronous active-low reset
//             inst_i              - instruction register contents
//             zero_i, lt_i, ltu_i - ALU compare flags for branches
//             mem_ready_i         - memory accepted/completed request
//             imm_sel_o           - immediate format (I=0,S=1,B=2,U=3,J=4)
//             alu_src_a_o/b_o, alu_op_o, result_sel_o, adr_sel_o - datapath muxes
//             mem_req_o, mem_we_o, ir_we_o, pc_we_o, reg_we_o     - enables
//             illegal_o, bus_err_o - sticky trap causes
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
    // Wait cycles allowed in a memory state before bus-error trap (0..255,
    // 0 disables the watchdog).
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_i,
    input  logic        zero_i,
    input  logic        lt_i,
    input  logic        ltu_i,
    input  logic        mem_ready_i,
    output logic [2:0]  imm_sel_o,
    output logic [1:0]  alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  alu_op_o,
    output logic [1:0]  result_sel_o,
    output logic        adr_sel_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic        reg_we_o,
    output logic        illegal_o,
    output logic        bus_err_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [3:0] c_FETCH   = 4'd0;
    localparam logic [3:0] c_DECODE  = 4'd1;
    localparam logic [3:0] c_MEMADR  = 4'd2;
    localparam logic [3:0] c_MEMRD   = 4'd3;
    localparam logic [3:0] c_MEMWB   = 4'd4;
    localparam logic [3:0] c_MEMWR   = 4'd5;
    localparam logic [3:0] c_EXECR   = 4'd6;
    localparam logic [3:0] c_EXECI   = 4'd7;
    localparam logic [3:0] c_ALUWB   = 4'd8;
    localparam logic [3:0] c_BRANCH  = 4'd9;
    localparam logic [3:0] c_JALRADR = 4'd10;
    localparam logic [3:0] c_JAL     = 4'd11;
    localparam logic [3:0] c_LUI     = 4'd12;
    localparam logic [3:0] c_AUIPC   = 4'd13;
    localparam logic [3:0] c_TRAP    = 4'd14;

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_IMM   = 7'b0010011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

    localparam logic [2:0] c_IMM_I = 3'd0;
    localparam logic [2:0] c_IMM_S = 3'd1;
    localparam logic [2:0] c_IMM_B = 3'd2;
    localparam logic [2:0] c_IMM_U = 3'd3;
    localparam logic [2:0] c_IMM_J = 3'd4;

    localparam logic [1:0] c_A_PC    = 2'd0;
    localparam logic [1:0] c_A_OLDPC = 2'd1;
    localparam logic [1:0] c_A_RS1   = 2'd2;
    localparam logic [1:0] c_A_ZERO  = 2'd3;
    localparam logic [1:0] c_B_RS2   = 2'd0;
    localparam logic [1:0] c_B_IMM   = 2'd1;
    localparam logic [1:0] c_B_FOUR  = 2'd2;
    localparam logic [1:0] c_OP_ADD  = 2'd0;
    localparam logic [1:0] c_OP_SUB  = 2'd1;
    localparam logic [1:0] c_OP_FN   = 2'd2;
    localparam logic [1:0] c_RES_ALUOUT = 2'd0;
    localparam logic [1:0] c_RES_DATA   = 2'd1;
    localparam logic [1:0] c_RES_ALU    = 2'd2;

    localparam logic [8:0] c_WAIT_LIMIT = 9'(MAX_WAIT);
    localparam logic       c_WD_EN      = (MAX_WAIT != 0);

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_unused_inst;

    assign w_opcode      = inst_i[6:0];
    assign w_funct3      = inst_i[14:12];
    // Remaining IR bits (incl. funct7b5) are consumed by the ALU decoder.
    assign w_unused_inst = ^{inst_i[31:15], inst_i[11:7]};

    // ------------------------------------------------------------------
    // State and bookkeeping registers
    // ------------------------------------------------------------------
    logic [3:0] state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       illegal_q, illegal_d;
    logic       bus_err_q, bus_err_d;

    logic       w_set_illegal;
    logic       w_set_bus_err;
    logic       w_mem_wait;
    logic       w_wd_expire;
    logic       w_taken;
    logic       w_branch_bad;

    // A memory state that is still waiting this cycle.
    assign w_mem_wait = ((state_q == c_FETCH) || (state_q == c_MEMRD) ||
                         (state_q == c_MEMWR)) && !mem_ready_i;

    // Expiry fires on the MAX_WAIT-th consecutive wait cycle; a mem_ready in
    // that same cycle is excluded by w_mem_wait, so completion wins.
    assign w_wd_expire = c_WD_EN && w_mem_wait &&
                         (({1'b0, wait_cnt_q} + 9'd1) == c_WAIT_LIMIT);

    // funct3 010/011 are not defined for branches.
    assign w_branch_bad = (w_funct3[2:1] == 2'b01);

    always_comb begin
        case (w_funct3)
            3'b000:  w_taken = zero_i;
            3'b001:  w_taken = !zero_i;
            3'b100:  w_taken = lt_i;
            3'b101:  w_taken = !lt_i;
            3'b110:  w_taken = ltu_i;
            3'b111:  w_taken = !ltu_i;
            default: w_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= c_FETCH;
            wait_cnt_q <= 8'd0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        w_set_illegal = 1'b0;
        w_set_bus_err = 1'b0;

        case (state_q)
            c_FETCH: begin
                if (mem_ready_i) begin
                    state_d = c_DECODE;
                end else if (w_wd_expire) begin
                    state_d       = c_TRAP;
                    w_set_bus_err = 1'b1;
                end
            end
            c_DECODE: begin
                case (w_opcode)
                    c_OP_LOAD, c_OP_STORE: state_d = c_MEMADR;
                    c_OP_R:                state_d = c_EXECR;
                    c_OP_IMM:              state_d = c_EXECI;
                    c_OP_BR:               state_d = c_BRANCH;
                    c_OP_JAL:              state_d = c_JAL;
                    c_OP_JALR:             state_d = c_JALRADR;
                    c_OP_LUI:              state_d = c_LUI;
                    c_OP_AUIPC:            state_d = c_AUIPC;
                    default: begin
                        state_d       = c_TRAP;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            c_MEMADR:  state_d = (w_opcode == c_OP_LOAD) ? c_MEMRD : c_MEMWR;
            c_MEMRD, c_MEMWR: begin
                if (mem_ready_i) begin
                    state_d = (state_q == c_MEMRD) ? c_MEMWB : c_FETCH;
                end else if (w_wd_expire) begin
                    state_d       = c_TRAP;
                    w_set_bus_err = 1'b1;
                end
            end
            c_MEMWB:   state_d = c_FETCH;
            c_EXECR:   state_d = c_ALUWB;
            c_EXECI:   state_d = c_ALUWB;
            c_ALUWB:   state_d = c_FETCH;
            c_BRANCH: begin
                if (w_branch_bad) begin
                    state_d       = c_TRAP;
                    w_set_illegal = 1'b1;
                end else begin
                    state_d = c_FETCH;
                end
            end
            c_JALRADR: state_d = c_JAL;
            c_JAL:     state_d = c_ALUWB;
            c_LUI:     state_d = c_ALUWB;
            c_AUIPC:   state_d = c_ALUWB;
            c_TRAP:    state_d = c_TRAP;
            default:   state_d = c_TRAP;
        endcase

        illegal_d = illegal_q | w_set_illegal;
        bus_err_d = bus_err_q | w_set_bus_err;

        // Counter restarts on every state change and saturates so a disabled
        // watchdog never wraps.
        if (state_d != state_q) begin
            wait_cnt_d = 8'd0;
        end else if (w_mem_wait && (wait_cnt_q != 8'hFF)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    assign illegal_o = illegal_q;
    assign bus_err_o = bus_err_q;

    always_comb begin
        imm_sel_o    = c_IMM_I;
        alu_src_a_o  = c_A_PC;
        alu_src_b_o  = c_B_RS2;
        alu_op_o     = c_OP_ADD;
        result_sel_o = c_RES_ALUOUT;
        adr_sel_o    = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        ir_we_o      = 1'b0;
        pc_we_o      = 1'b0;
        reg_we_o     = 1'b0;

        // While reset is asserted everything stays at the idle values.
        if (rst_n) begin
            case (w_opcode)
                c_OP_STORE:           imm_sel_o = c_IMM_S;
                c_OP_BR:              imm_sel_o = c_IMM_B;
                c_OP_LUI, c_OP_AUIPC: imm_sel_o = c_IMM_U;
                c_OP_JAL:             imm_sel_o = c_IMM_J;
                default:              imm_sel_o = c_IMM_I;
            endcase

            case (state_q)
                c_FETCH: begin
                    mem_req_o    = 1'b1;
                    alu_src_b_o  = c_B_FOUR;
                    result_sel_o = c_RES_ALU;
                    ir_we_o      = mem_ready_i;
                    pc_we_o      = mem_ready_i;
                end
                c_DECODE: begin
                    alu_src_a_o = c_A_OLDPC;
                    alu_src_b_o = c_B_IMM;
                end
                c_MEMADR, c_JALRADR: begin
                    alu_src_a_o = c_A_RS1;
                    alu_src_b_o = c_B_IMM;
                end
                c_MEMRD: begin
                    mem_req_o = 1'b1;
                    adr_sel_o = 1'b1;
                end
                c_MEMWB: begin
                    reg_we_o     = 1'b1;
                    result_sel_o = c_RES_DATA;
                end
                c_MEMWR: begin
                    mem_req_o = 1'b1;
                    mem_we_o  = 1'b1;
                    adr_sel_o = 1'b1;
                end
                c_EXECR: begin
                    alu_src_a_o = c_A_RS1;
                    alu_op_o    = c_OP_FN;
                end
                c_EXECI: begin
                    alu_src_a_o = c_A_RS1;
                    alu_src_b_o = c_B_IMM;
                    alu_op_o    = c_OP_FN;
                end
                c_ALUWB:   reg_we_o = 1'b1;
                c_BRANCH: begin
                    alu_src_a_o = c_A_RS1;
                    alu_op_o    = c_OP_SUB;
                    pc_we_o     = w_taken;
                end
                c_JAL: begin
                    // PC takes the target from ALUOUT while the ALU forms
                    // OLDPC+4 for the link write in ALUWB.
                    pc_we_o     = 1'b1;
                    alu_src_a_o = c_A_OLDPC;
                    alu_src_b_o = c_B_FOUR;
                end
                c_LUI: begin
                    alu_src_a_o = c_A_ZERO;
                    alu_src_b_o = c_B_IMM;
                end
                c_AUIPC: begin
                    alu_src_a_o = c_A_OLDPC;
                    alu_src_b_o = c_B_IMM;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
//  Module   : tb_multicycle_ctrl
//  Purpose  : Self-checking bench for multicycle_ctrl. A plan-based model
//             (per-instruction list of steps) predicts every output each
//             cycle; directed tests add literal checks on key cycles.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst;
    logic        zero, lt, ltu, mem_ready;
    logic [2:0]  imm_sel;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_sel;
    logic        adr_sel, mem_req, mem_we, ir_we, pc_we, reg_we, illegal, bus_err;
    logic [18:0] dut_vec;

    int          n_cmp;
    int          n_err;

    string       m_step;
    string       m_plan[$];
    int          m_wait;
    logic        m_ill, m_bus;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MAX_WAIT(MW)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst_i       (inst),
        .zero_i       (zero),
        .lt_i         (lt),
        .ltu_i        (ltu),
        .mem_ready_i  (mem_ready),
        .imm_sel_o    (imm_sel),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .alu_op_o     (alu_op),
        .result_sel_o (result_sel),
        .adr_sel_o    (adr_sel),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .ir_we_o      (ir_we),
        .pc_we_o      (pc_we),
        .reg_we_o     (reg_we),
        .illegal_o    (illegal),
        .bus_err_o    (bus_err)
    );

    assign dut_vec = {imm_sel, alu_src_a, alu_src_b, alu_op, result_sel, adr_sel,
                      mem_req, mem_we, ir_we, pc_we, reg_we, illegal, bus_err};

    // ---------------- model ----------------
    function automatic logic [2:0] imm_model(input logic [6:0] op);
        if (op == 7'h23) return 3'd1;
        if (op == 7'h63) return 3'd2;
        if (op == 7'h37 || op == 7'h17) return 3'd3;
        if (op == 7'h6F) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic taken_model(input logic [2:0] f3, input logic z,
                                         input logic l, input logic lu);
        if (f3 == 3'd0) return z;
        if (f3 == 3'd1) return !z;
        if (f3 == 3'd4) return l;
        if (f3 == 3'd5) return !l;
        if (f3 == 3'd6) return lu;
        if (f3 == 3'd7) return !lu;
        return 1'b0;
    endfunction

    function automatic logic [18:0] model_out(input string st, input logic [31:0] in,
        input logic rn, input logic rdy, input logic z, input logic l, input logic lu,
        input logic fi, input logic fb);
        logic [2:0] ims;
        logic [1:0] a, b, op, res;
        logic       adr, req, we, ir, pc, rw;
        ims = 3'd0; a = 2'd0; b = 2'd0; op = 2'd0; res = 2'd0;
        adr = 1'b0; req = 1'b0; we = 1'b0; ir = 1'b0; pc = 1'b0; rw = 1'b0;
        if (rn) begin
            ims = imm_model(in[6:0]);
            if (st == "FETCH") begin
                req = 1'b1; b = 2'd2; res = 2'd2; ir = rdy; pc = rdy;
            end else if (st == "DECODE" || st == "AUIPC") begin
                a = 2'd1; b = 2'd1;
            end else if (st == "MEMADR" || st == "JALRADR") begin
                a = 2'd2; b = 2'd1;
            end else if (st == "MEMRD") begin
                req = 1'b1; adr = 1'b1;
            end else if (st == "MEMWB") begin
                rw = 1'b1; res = 2'd1;
            end else if (st == "MEMWR") begin
                req = 1'b1; we = 1'b1; adr = 1'b1;
            end else if (st == "EXECR") begin
                a = 2'd2; op = 2'd2;
            end else if (st == "EXECI") begin
                a = 2'd2; b = 2'd1; op = 2'd2;
            end else if (st == "ALUWB") begin
                rw = 1'b1;
            end else if (st == "BRANCH") begin
                a = 2'd2; op = 2'd1; pc = taken_model(in[14:12], z, l, lu);
            end else if (st == "JAL") begin
                pc = 1'b1; a = 2'd1; b = 2'd2;
            end else if (st == "LUI") begin
                a = 2'd3; b = 2'd1;
            end
        end
        return {ims, a, b, op, res, adr, req, we, ir, pc, rw, fi, fb};
    endfunction

    task automatic next_step();
        m_wait = 0;
        if (m_plan.size() > 0) m_step = m_plan.pop_front();
        else                   m_step = "FETCH";
    endtask

    task automatic model_update();
        if (!rst_n) begin
            m_step = "FETCH"; m_plan.delete(); m_wait = 0; m_ill = 1'b0; m_bus = 1'b0;
        end else if (m_step == "TRAP") begin
        end else if (m_step == "FETCH" || m_step == "MEMRD" || m_step == "MEMWR") begin
            if (mem_ready) begin
                if (m_step == "FETCH") begin m_wait = 0; m_step = "DECODE"; end
                else next_step();
            end else begin
                m_wait++;
                if (MW != 0 && m_wait == MW) begin m_step = "TRAP"; m_bus = 1'b1; end
            end
        end else if (m_step == "DECODE") begin
            case (inst[6:0])
                7'h03: m_plan = '{"MEMADR", "MEMRD", "MEMWB"};
                7'h23: m_plan = '{"MEMADR", "MEMWR"};
                7'h33: m_plan = '{"EXECR", "ALUWB"};
                7'h13: m_plan = '{"EXECI", "ALUWB"};
                7'h63: m_plan = '{"BRANCH"};
                7'h6F: m_plan = '{"JAL", "ALUWB"};
                7'h67: m_plan = '{"JALRADR", "JAL", "ALUWB"};
                7'h37: m_plan = '{"LUI", "ALUWB"};
                7'h17: m_plan = '{"AUIPC", "ALUWB"};
                default: m_plan.delete();
            endcase
            if (m_plan.size() == 0) begin m_step = "TRAP"; m_ill = 1'b1; end
            else next_step();
        end else if (m_step == "BRANCH") begin
            if (inst[14:12] == 3'd2 || inst[14:12] == 3'd3) begin
                m_step = "TRAP"; m_ill = 1'b1;
            end else next_step();
        end else begin
            next_step();
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Per-cycle model comparison on the falling edge.
    task automatic sample();
        logic [18:0] e;
        @(negedge clk);
        e = model_out(m_step, inst, rst_n, mem_ready, zero, lt, ltu, m_ill, m_bus);
        chk({"model_", m_step}, 32'(dut_vec), 32'(e));
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic chk_fetch(input string nm);
        chk(nm, 32'({mem_req, adr_sel, mem_we}), 32'(3'b100));
    endtask

    task automatic release_reset(input string nm);
        rst_n = 1'b1;
        #1;
        chk_fetch(nm);
        chk({nm, "_flags"}, 32'({illegal, bus_err}), 32'd0);
    endtask

    task automatic run_insn(input string nm, input logic [31:0] in, input logic z,
                            input logic l, input logic lu, input int cpi);
        int   c;
        logic hit;
        inst = in; zero = z; lt = l; ltu = lu; mem_ready = 1'b1;
        c = 0; hit = 1'b0;
        while (!hit && c < 20) begin
            sample();
            adv();
            c++;
            hit = mem_req && !adr_sel && !mem_we;
        end
        chk({"cpi_", nm}, 32'(c), 32'(cpi));
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] tv_inst [8] = '{32'h00A48433, 32'h0094A023, 32'h123450B7, 32'h00001097,
                                 32'h000480E7, 32'h00A49463, 32'h00A4C463, 32'h00A4F463};
    logic [2:0]  tv_flg  [8] = '{3'b000, 3'b000, 3'b000, 3'b000,
                                 3'b000, 3'b000, 3'b000, 3'b001};
    int          tv_cpi  [8] = '{4, 4, 4, 4, 5, 3, 3, 3};

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        n_cmp = 0; n_err = 0;
        m_step = "FETCH"; m_wait = 0; m_ill = 1'b0; m_bus = 1'b0;
        rst_n = 1'b0; inst = 32'd0; zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;

        // Reset
        adv();
        sample();
        chk("reset_enables", 32'({mem_req, mem_we, ir_we, pc_we, reg_we}), 32'd0);
        chk("reset_selects", 32'({imm_sel, alu_src_a, alu_src_b, alu_op, result_sel, adr_sel}), 32'd0);
        chk("reset_flags", 32'({illegal, bus_err}), 32'd0);
        adv();

        // addi: FETCH DECODE EXECI ALUWB
        rst_n = 1'b1; inst = 32'h00C48413; mem_ready = 1'b1;
        sample(); chk("addi_c1_irpc", 32'({ir_we, pc_we, reg_we}), 32'(3'b110));
        chk("addi_imm", 32'(imm_sel), 32'd0); adv();
        sample(); chk("addi_c2_en", 32'({ir_we, pc_we, reg_we}), 32'd0); adv();
        sample(); chk("addi_c3_alu", 32'({alu_src_a, alu_src_b, alu_op, reg_we}), 32'(7'b10_01_10_0)); adv();
        sample(); chk("addi_c4_regwe", 32'({ir_we, pc_we, reg_we}), 32'(3'b001)); adv();
        chk_fetch("addi_4cyc");

        // lw with 3 wait cycles in MEMRD (ready lands on the watchdog's last cycle)
        inst = 32'h0004A403; mem_ready = 1'b1;
        sample(); adv();
        sample(); adv();
        sample(); chk("lw_memadr", 32'({alu_src_a, alu_src_b, alu_op}), 32'(6'b10_01_00)); adv();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            sample(); chk("lw_memrd_hold", 32'({mem_req, adr_sel, mem_we}), 32'(3'b110)); adv();
        end
        sample(); chk("lw_memwb", 32'({reg_we, result_sel, bus_err}), 32'(4'b1_01_0)); adv();
        chk_fetch("lw_8cyc");

        // beq taken / not taken
        for (int k = 0; k < 2; k++) begin
            inst = 32'h00A48E63; zero = (k == 0); mem_ready = 1'b1;
            sample(); chk("beq_imm", 32'(imm_sel), 32'd2); adv();
            sample(); adv();
            sample(); chk((k == 0) ? "beq_taken_pcwe" : "beq_nottaken_pcwe", 32'(pc_we), 32'(k == 0)); adv();
            chk_fetch("beq_3cyc");
        end
        zero = 1'b0;

        // jal
        inst = 32'h7FFFF0EF;
        sample(); chk("jal_imm", 32'(imm_sel), 32'd4); adv();
        sample(); adv();
        sample(); chk("jal_state", 32'({pc_we, result_sel, alu_src_a, alu_src_b, reg_we}), 32'(8'b1_00_01_10_0)); adv();
        sample(); chk("jal_aluwb", 32'({reg_we, pc_we}), 32'(2'b10)); adv();
        chk_fetch("jal_4cyc");

        // Table: add, sw, lui, auipc, jalr, bne, blt, bgeu
        for (int t = 0; t < 8; t++)
            run_insn($sformatf("tv%0d", t), tv_inst[t], tv_flg[t][2], tv_flg[t][1], tv_flg[t][0], tv_cpi[t]);

        // Illegal opcode: sticky trap, cleared by one reset edge
        inst = 32'hFFFFFFFF; mem_ready = 1'b1;
        sample(); adv();
        sample(); chk("ill_decode_flag", 32'(illegal), 32'd0); adv();
        for (int i = 0; i < 20; i++) begin
            sample();
            if (i == 0 || i == 19)
                chk("ill_trap_hold", 32'({illegal, mem_req, mem_we, ir_we, pc_we, reg_we}), 32'(6'b100000));
            adv();
        end
        rst_n = 1'b0;
        sample(); chk("ill_reset_cycle", 32'({mem_req, ir_we, pc_we}), 32'd0); adv();
        release_reset("ill_restart");

        // Branch with undefined funct3 traps after BRANCH
        inst = 32'h00A4A063;
        sample(); adv(); sample(); adv();
        sample(); chk("brbad_pcwe", 32'(pc_we), 32'd0); adv();
        sample(); chk("brbad_trap", 32'({illegal, mem_req}), 32'(2'b10)); adv();
        rst_n = 1'b0; sample(); adv();
        release_reset("brbad_restart");

        // Watchdog expiry in FETCH
        inst = 32'h00C48413; mem_ready = 1'b0;
        for (int i = 0; i < MW; i++) begin
            sample(); chk("wd_fetch_wait", 32'({mem_req, adr_sel, bus_err}), 32'(3'b100)); adv();
        end
        sample(); chk("wd_trap", 32'({bus_err, mem_req, illegal}), 32'(3'b100)); adv();
        rst_n = 1'b0; sample(); adv();
        release_reset("wd_restart");

        // Reset during a MEMWR wait
        inst = 32'h0094A023; mem_ready = 1'b1;
        sample(); adv(); sample(); adv(); sample(); adv();
        mem_ready = 1'b0;
        sample(); chk("sw_memwr", 32'({mem_req, mem_we, adr_sel}), 32'(3'b111)); adv();
        sample(); adv();
        rst_n = 1'b0;
        sample(); chk("sw_reset_req", 32'({mem_req, mem_we}), 32'd0); adv();
        release_reset("sw_restart");
        run_insn("after_reset_addi", 32'h00C48413, 1'b0, 1'b0, 1'b0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
